reel_controller: RTL and testbench

//  Downstream consumer of the 3-bit random generator in the slot machine.

---
 rtl/slot_pkg.sv | 36 +++
 rtl/slot_win_eval.sv | 36 +++
 rtl/reel_controller.sv | 155 +++++++++++++++
 tb/tb_reel_controller.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// ============================================================================
// Module : slot_pkg
// Brief  : Shared types, constants and symbol mapping for the slot machine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package slot_pkg;

    localparam int SYM_W = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPIN  = 3'd1,
        LOCK0 = 3'd2,
        WAIT1 = 3'd3,
        WAIT2 = 3'd4,
        EVAL  = 3'd5,
        SHOW  = 3'd6
    } state_t;

    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_PAIR   = 2'b01;
    localparam logic [1:0] WIN_TRIPLE = 2'b10;

    // Folds a raw generator value into 0..nsym-1 (nsym is 4..8, so one subtract suffices)
    function automatic logic [SYM_W-1:0] sym_map(input logic [SYM_W-1:0] rnd,
                                                 input logic [SYM_W:0]   nsym);
        logic [SYM_W-1:0] w_diff;
        w_diff = rnd - nsym[SYM_W-1:0];
        return ({1'b0, rnd} < nsym) ? rnd : w_diff;
    endfunction

endpackage

`default_nettype wire

// File: rtl/slot_win_eval.sv
// ============================================================================
// Module : slot_win_eval
// Brief  : Combinational win classification of three reel symbols.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module slot_win_eval
    import slot_pkg::*;
(
    input  logic [SYM_W-1:0] i_a,
    input  logic [SYM_W-1:0] i_b,
    input  logic [SYM_W-1:0] i_c,
    output logic [1:0]       o_win
);

    logic w_ab;
    logic w_bc;
    logic w_ac;

    assign w_ab = (i_a == i_b);
    assign w_bc = (i_b == i_c);
    assign w_ac = (i_a == i_c);

    always_comb begin
        o_win = WIN_NONE;
        if (w_ab && w_bc) begin
            o_win = WIN_TRIPLE;
        end else if (w_ab || w_bc || w_ac) begin
            o_win = WIN_PAIR;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reel_controller.sv
// ============================================================================
// Module : reel_controller
// Brief  : Spin / stop / staggered reel lock sequencer with win evaluation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reel_controller
    import slot_pkg::*;
#(
    parameter int unsigned NUM_SYMBOLS     = 8,
    parameter int unsigned SETTLE_TICKS    = 3,
    parameter int unsigned AUTO_STOP_TICKS = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic [SYM_W-1:0] rnd,
    output logic             rnd_en,
    output logic [SYM_W-1:0] reel0,
    output logic [SYM_W-1:0] reel1,
    output logic [SYM_W-1:0] reel2,
    output logic             spinning,
    output logic             done,
    output logic [1:0]       win_code
);

    localparam logic [SYM_W-1:0] c_LAST_SYM    = SYM_W'(NUM_SYMBOLS - 1);
    localparam logic [SYM_W:0]   c_NSYM        = (SYM_W + 1)'(NUM_SYMBOLS);
    localparam logic [3:0]       c_SETTLE_LAST = 4'(SETTLE_TICKS - 1);
    localparam logic [7:0]       c_AUTO_LAST   = 8'(AUTO_STOP_TICKS - 1);

    state_t           r_state;
    logic [7:0]       r_spin_cnt;
    logic [3:0]       r_settle_cnt;
    logic [SYM_W-1:0] r_reel0;
    logic [SYM_W-1:0] r_reel1;
    logic [SYM_W-1:0] r_reel2;
    logic             r_rnd_en;
    logic             r_spinning;
    logic             r_done;
    logic [1:0]       r_win;

    logic [SYM_W-1:0] w_sym;
    logic [1:0]       w_win;

    function automatic logic [SYM_W-1:0] f_roll(input logic [SYM_W-1:0] v);
        return (v == c_LAST_SYM) ? '0 : v + 1'b1;
    endfunction

    assign w_sym = sym_map(rnd, c_NSYM);

    slot_win_eval u_win_eval (
        .i_a   (r_reel0),
        .i_b   (r_reel1),
        .i_c   (r_reel2),
        .o_win (w_win)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_spin_cnt   <= '0;
            r_settle_cnt <= '0;
            r_reel0      <= '0;
            r_reel1      <= '0;
            r_reel2      <= '0;
            r_rnd_en     <= 1'b0;
            r_spinning   <= 1'b0;
            r_done       <= 1'b0;
            r_win        <= WIN_NONE;
        end else begin
            case (r_state)
                IDLE, SHOW: begin
                    if (start) begin
                        r_state    <= SPIN;
                        r_spin_cnt <= '0;
                        r_rnd_en   <= 1'b1;
                        r_spinning <= 1'b1;
                        r_done     <= 1'b0;
                        r_win      <= WIN_NONE;
                    end
                end
                SPIN: begin
                    // A player stop pre-empts a coincident tick: no roll that cycle
                    if (stop) begin
                        r_state <= LOCK0;
                    end else if (tick) begin
                        r_reel0 <= f_roll(r_reel0);
                        r_reel1 <= f_roll(r_reel1);
                        r_reel2 <= f_roll(r_reel2);
                        if (r_spin_cnt == c_AUTO_LAST) begin
                            r_state <= LOCK0;
                        end
                        if (r_spin_cnt != 8'hFF) begin
                            r_spin_cnt <= r_spin_cnt + 8'd1;
                        end
                    end
                end
                LOCK0: begin
                    r_reel0      <= w_sym;
                    r_settle_cnt <= '0;
                    r_state      <= WAIT1;
                end
                WAIT1: begin
                    if (tick) begin
                        r_reel2 <= f_roll(r_reel2);
                        if (r_settle_cnt == c_SETTLE_LAST) begin
                            r_reel1      <= w_sym;
                            r_settle_cnt <= '0;
                            r_state      <= WAIT2;
                        end else begin
                            r_reel1      <= f_roll(r_reel1);
                            r_settle_cnt <= r_settle_cnt + 4'd1;
                        end
                    end
                end
                WAIT2: begin
                    if (tick) begin
                        if (r_settle_cnt == c_SETTLE_LAST) begin
                            r_reel2    <= w_sym;
                            r_rnd_en   <= 1'b0;
                            r_spinning <= 1'b0;
                            r_state    <= EVAL;
                        end else begin
                            r_reel2      <= f_roll(r_reel2);
                            r_settle_cnt <= r_settle_cnt + 4'd1;
                        end
                    end
                end
                EVAL: begin
                    r_win   <= w_win;
                    r_done  <= 1'b1;
                    r_state <= SHOW;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rnd_en   = r_rnd_en;
    assign reel0    = r_reel0;
    assign reel1    = r_reel1;
    assign reel2    = r_reel2;
    assign spinning = r_spinning;
    assign done     = r_done;
    assign win_code = r_win;

endmodule

`default_nettype wire

// File: tb/tb_reel_controller.sv
// ============================================================================
// Module : tb_reel_controller
// Brief  : Directed scoreboard bench for reel_controller (default and 6-symbol builds).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reel_controller;

    typedef struct packed {
        logic [2:0] r0;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [1:0] w;
    } res_t;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start;
    logic       start6;
    logic       stop;
    logic [2:0] rnd;

    logic       rnd_en, spinning, done;
    logic [2:0] reel0, reel1, reel2;
    logic [1:0] win_code;

    logic       rnd_en6, spinning6, done6;
    logic [2:0] reel0_6, reel1_6, reel2_6;
    logic [1:0] win_code6;

    int   checks = 0;
    int   errors = 0;
    res_t q_exp[$];
    res_t q_exp6[$];
    logic done_d  = 1'b0;
    logic done6_d = 1'b0;
    logic [1:0] last_win = 2'b00;

    reel_controller u_dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .start    (start),
        .stop     (stop),
        .rnd      (rnd),
        .rnd_en   (rnd_en),
        .reel0    (reel0),
        .reel1    (reel1),
        .reel2    (reel2),
        .spinning (spinning),
        .done     (done),
        .win_code (win_code)
    );

    reel_controller #(
        .NUM_SYMBOLS     (6),
        .SETTLE_TICKS    (1),
        .AUTO_STOP_TICKS (40)
    ) u_dut6 (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .start    (start6),
        .stop     (stop),
        .rnd      (rnd),
        .rnd_en   (rnd_en6),
        .reel0    (reel0_6),
        .reel1    (reel1_6),
        .reel2    (reel2_6),
        .spinning (spinning6),
        .done     (done6),
        .win_code (win_code6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] tsym(input logic [2:0] r, input int ns);
        return (int'(r) < ns) ? r : 3'(int'(r) - ns);
    endfunction

    function automatic logic [1:0] twin(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        if (a == b && b == c) return 2'b10;
        if (a == b || b == c || a == c) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_res(input string nm, input res_t got, input res_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got reels %0d/%0d/%0d win %b expected %0d/%0d/%0d win %b",
                     nm, got.r0, got.r1, got.r2, got.w, exp.r0, exp.r1, exp.r2, exp.w);
        end
    endtask

    // Result monitor: checks each completed spin against the queued expectation
    always @(negedge clk) begin
        if (done && !done_d) begin
            if (q_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result: unexpected done, no expected entry queued");
            end else begin
                cmp_res("result", {reel0, reel1, reel2, win_code}, q_exp.pop_front());
            end
        end
        if (done6 && !done6_d) begin
            if (q_exp6.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result6: unexpected done, no expected entry queued");
            end else begin
                cmp_res("result6", {reel0_6, reel1_6, reel2_6, win_code6}, q_exp6.pop_front());
            end
        end
        done_d  = done;
        done6_d = done6;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_spin();
        chk("win_hold", {6'd0, win_code}, {6'd0, last_win});
        start = 1'b1;
        step();
        start = 1'b0;
        chk("spin_rnd_en", {7'd0, rnd_en}, 8'd1);
        chk("spin_spinning", {7'd0, spinning}, 8'd1);
        chk("spin_done_clr", {7'd0, done}, 8'd0);
        chk("spin_win_clr", {6'd0, win_code}, 8'd0);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    task automatic stop_lock0(input logic [2:0] a, input bit with_tick);
        logic [2:0] prev1;
        prev1 = reel1;
        rnd   = a;
        stop  = 1'b1;
        tick  = with_tick;
        step();
        stop  = 1'b0;
        tick  = 1'b0;
        if (with_tick) chk("stop_tick_noroll", {5'd0, reel1}, {5'd0, prev1});
        step();
        chk("lock0_reel0", {5'd0, reel0}, {5'd0, tsym(a, 8)});
        chk("lock0_rnd_en", {7'd0, rnd_en}, 8'd1);
    endtask

    task automatic lock_rest(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                             input bit hold, input bit stop_w2);
        res_t e;
        e.r0 = tsym(a, 8);
        e.r1 = tsym(b, 8);
        e.r2 = tsym(c, 8);
        e.w  = twin(e.r0, e.r1, e.r2);
        q_exp.push_back(e);
        last_win = e.w;
        for (int i = 0; i < 3; i++) begin
            rnd  = (hold || i == 2) ? b : (b ^ 3'b100);
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (i == 2) chk("lock1_reel1", {5'd0, reel1}, {5'd0, e.r1});
            else        chk("wait1_spinning", {7'd0, spinning}, 8'd1);
            stop = stop_w2 && (i == 2);
            step();
            stop = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            rnd  = (hold || i == 2) ? c : (c ^ 3'b100);
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (i == 2) begin
                chk("lock2_reel2", {5'd0, reel2}, {5'd0, e.r2});
                chk("lock2_spinning", {7'd0, spinning}, 8'd0);
                chk("lock2_rnd_en", {7'd0, rnd_en}, 8'd0);
            end else begin
                chk("wait2_rnd_en", {7'd0, rnd_en}, 8'd1);
            end
            step();
        end
        chk("show_done", {7'd0, done}, 8'd1);
        step();
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; start6 = 1'b0; stop = 1'b0; rnd = 3'd0;
        step();
        step();
        chk("rst_reel0", {5'd0, reel0}, 8'd0);
        chk("rst_rnd_en", {7'd0, rnd_en}, 8'd0);
        chk("rst_spinning", {7'd0, spinning}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_win", {6'd0, win_code}, 8'd0);
        reset = 1'b0;
        step();

        // start and stop together in IDLE: stop must be dropped
        rnd = 3'd6; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("ss_spinning", {7'd0, spinning}, 8'd1);
        step();
        step();
        chk("ss_stop_dropped", {5'd0, reel0}, 8'd0);
        do_ticks(5);
        chk("roll5_reel0", {5'd0, reel0}, 8'd5);
        chk("roll5_rnd_en", {7'd0, rnd_en}, 8'd1);
        stop_lock0(3'd5, 1'b0);
        lock_rest(3'd5, 3'd5, 3'd3, 1'b0, 1'b0);

        begin_spin();
        do_ticks(2);
        stop_lock0(3'd2, 1'b0);
        lock_rest(3'd2, 3'd2, 3'd2, 1'b1, 1'b0);

        begin_spin();
        do_ticks(1);
        stop_lock0(3'd4, 1'b1);
        lock_rest(3'd4, 3'd4, 3'd1, 1'b0, 1'b0);

        begin_spin();
        do_ticks(3);
        stop_lock0(3'd0, 1'b0);
        lock_rest(3'd0, 3'd3, 3'd6, 1'b0, 1'b0);

        // auto stop: reel0 starts at 0, start pulsed mid-spin must not restart the count
        begin_spin();
        rnd = 3'd3;
        for (int i = 1; i <= 39; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            start = (i == 10);
            step();
            start = 1'b0;
        end
        chk("auto_39_reel0", {5'd0, reel0}, 8'd7);
        chk("auto_39_spinning", {7'd0, spinning}, 8'd1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        chk("auto_lock0_reel0", {5'd0, reel0}, 8'd3);
        lock_rest(3'd3, 3'd3, 3'd3, 1'b0, 1'b1);

        // 6-symbol build, one tick per reel lock
        start6 = 1'b1;
        step();
        start6 = 1'b0;
        q_exp6.push_back({3'd1, 3'd5, 3'd5, 2'b01});
        rnd = 3'd7; stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        chk("ns6_map7", {5'd0, reel0_6}, 8'd1);
        rnd = 3'd5; tick = 1'b1;
        step();
        tick = 1'b0;
        chk("ns6_reel1", {5'd0, reel1_6}, 8'd5);
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("ns6_reel2", {5'd0, reel2_6}, 8'd5);
        step();
        step();
        start6 = 1'b1;
        step();
        start6 = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("ns6_wrap_reel1", {5'd0, reel1_6}, 8'd0);
        chk("ns6_roll_reel0", {5'd0, reel0_6}, 8'd2);
        q_exp6.push_back({3'd0, 3'd3, 3'd0, 2'b01});
        rnd = 3'd6; stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        chk("ns6_map6", {5'd0, reel0_6}, 8'd0);
        rnd = 3'd3; tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        rnd = 3'd0; tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();

        // asynchronous reset in the middle of WAIT1
        begin_spin();
        rnd = 3'd1; stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        chk("pre_rst_reel0", {5'd0, reel0}, 8'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_reel0", {5'd0, reel0}, 8'd0);
        chk("arst_reel2", {5'd0, reel2}, 8'd0);
        chk("arst_rnd_en", {7'd0, rnd_en}, 8'd0);
        chk("arst_spinning", {7'd0, spinning}, 8'd0);
        chk("arst_done", {7'd0, done}, 8'd0);
        step();
        reset = 1'b0;
        last_win = 2'b00;
        tick = 1'b1;
        step();
        tick = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        chk("idle_noroll_reel1", {5'd0, reel1}, 8'd0);
        chk("idle_spinning", {7'd0, spinning}, 8'd0);
        begin_spin();
        do_ticks(2);
        stop_lock0(3'd1, 1'b0);
        lock_rest(3'd1, 3'd2, 3'd1, 1'b0, 1'b0);

        step();
        step();
        if (q_exp.size() != 0 || q_exp6.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending: got %0d/%0d results outstanding expected 0", q_exp.size(), q_exp6.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
